// File: rtl/dm_responder_if.sv
// Request/response channel bundle between the CPU memory stage and dm_responder.
// The CPU drives the master modport; the responder takes the slave modport.
interface dm_responder_if;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWr;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic [3:0]  ReqBE;
    logic        RespValid;
    logic        RespReady;
    logic [31:0] RespRData;
    logic        RespErr;

    modport master (
        output ReqValid, ReqWr, ReqAddr, ReqWData, ReqBE, RespReady,
        input  ReqReady, RespValid, RespRData, RespErr
    );

    modport slave (
        input  ReqValid, ReqWr, ReqAddr, ReqWData, ReqBE, RespReady,
        output ReqReady, RespValid, RespRData, RespErr
    );
endinterface

// File: rtl/dm_responder.sv
// Fixed-latency word RAM responder for the CPU data-memory port.
// Optional DM_ALIGN_CHECK_EN: flags misaligned addresses and illegal store byte-enable patterns.
module dm_responder #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned LATENCY    = 2
) (
    input logic           Clk,
    input logic           Reset,
    dm_responder_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    localparam int unsigned Words  = 1 << DEPTH_LOG2;
    localparam bit          Direct = (LATENCY == 1);

    state_t      stateQ, stateD;
    logic [3:0]  cntQ, cntD;
    logic        wrQ;
    logic [31:0] addrQ, wdataQ;
    logic [3:0]  beQ;
    logic [31:0] rdataQ, rdataD;
    logic        errQ, errD;

    logic        accept;
    logic        execute;
    logic        execWr;
    logic [31:0] execAddr, execWData;
    logic [3:0]  execBe;
    logic [DEPTH_LOG2-1:0] execIdx;
    logic        execErr;
    logic        memWe;

    logic [31:0] mem [Words];

    assign bus.ReqReady  = (stateQ == StIdle) | ((stateQ == StResp) & bus.RespReady);
    assign accept        = bus.ReqValid & bus.ReqReady;
    assign bus.RespValid = (stateQ == StResp);
    assign bus.RespRData = rdataQ;
    assign bus.RespErr   = errQ;

    // With a single-cycle latency the access executes on the accept edge, so use the live request.
    assign execWr    = Direct ? bus.ReqWr    : wrQ;
    assign execAddr  = Direct ? bus.ReqAddr  : addrQ;
    assign execWData = Direct ? bus.ReqWData : wdataQ;
    assign execBe    = Direct ? bus.ReqBE    : beQ;
    assign execIdx   = execAddr[DEPTH_LOG2+1:2];

`ifdef DM_ALIGN_CHECK_EN
    logic beLegal;

    always_comb begin
        beLegal = 1'b0;
        case (execBe)
            4'b1111, 4'b0011, 4'b1100,
            4'b0001, 4'b0010, 4'b0100, 4'b1000: beLegal = 1'b1;
            default:                            beLegal = 1'b0;
        endcase
    end

    assign execErr = (|execAddr[31:DEPTH_LOG2+2]) | (|execAddr[1:0]) | (execWr & ~beLegal);
`else
    logic unusedAddrLow;

    assign unusedAddrLow = ^execAddr[1:0];
    assign execErr       = |execAddr[31:DEPTH_LOG2+2];
`endif

    always_comb begin
        stateD  = stateQ;
        cntD    = cntQ;
        execute = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (accept) begin
                    cntD = 4'(LATENCY - 1);
                    if (Direct) begin
                        stateD  = StResp;
                        execute = 1'b1;
                    end else begin
                        stateD = StWait;
                    end
                end
            end
            StWait: begin
                cntD = cntQ - 4'd1;
                if (cntQ == 4'd1) begin
                    stateD  = StResp;
                    execute = 1'b1;
                end
            end
            StResp: begin
                if (accept) begin
                    cntD = 4'(LATENCY - 1);
                    if (Direct) begin
                        stateD  = StResp;
                        execute = 1'b1;
                    end else begin
                        stateD = StWait;
                    end
                end else if (bus.RespReady) begin
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        rdataD = 32'h0;
        errD   = execErr;
        if (!execWr && !execErr) begin
            rdataD = mem[execIdx];
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stateQ <= StIdle;
            cntQ   <= 4'd0;
            wrQ    <= 1'b0;
            addrQ  <= 32'h0;
            wdataQ <= 32'h0;
            beQ    <= 4'h0;
            rdataQ <= 32'h0;
            errQ   <= 1'b0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            if (accept) begin
                wrQ    <= bus.ReqWr;
                addrQ  <= bus.ReqAddr;
                wdataQ <= bus.ReqWData;
                beQ    <= bus.ReqBE;
            end
            if (execute) begin
                rdataQ <= rdataD;
                errQ   <= errD;
            end
        end
    end

    // Storage has no reset; gating with Reset keeps an in-reset edge from committing a store.
    assign memWe = execute & Reset & execWr & ~execErr;

    always_ff @(posedge Clk) begin
        if (memWe) begin
            for (int i = 0; i < 4; i++) begin
                if (execBe[i]) begin
                    mem[execIdx][8*i +: 8] <= execWData[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder: instance A uses LATENCY=2, instance B LATENCY=4.
module tb_dm_responder;

    logic Clk;
    logic rstA;
    logic rstB;
    int   checks;
    int   failures;

    dm_responder_if busA ();
    dm_responder_if busB ();

    dm_responder #(.DEPTH_LOG2(12), .LATENCY(2)) dutA (.Clk(Clk), .Reset(rstA), .bus(busA));
    dm_responder #(.DEPTH_LOG2(12), .LATENCY(4)) dutB (.Clk(Clk), .Reset(rstB), .bus(busB));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit useB, input logic valid, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input logic respReady);
        if (useB) begin
            busB.ReqValid = valid; busB.ReqWr = wr; busB.ReqAddr = addr;
            busB.ReqWData = wdata; busB.ReqBE = be; busB.RespReady = respReady;
        end else begin
            busA.ReqValid = valid; busA.ReqWr = wr; busA.ReqAddr = addr;
            busA.ReqWData = wdata; busA.ReqBE = be; busA.RespReady = respReady;
        end
    endtask

    function automatic logic respValidOf(input bit useB);
        return useB ? busB.RespValid : busA.RespValid;
    endfunction

    // One full transaction with RespReady held high; returns the response and checks latency.
    task automatic txn(input bit useB, input string tag, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int expLat,
                       output logic [31:0] rdata, output logic err);
        int lat;
        @(negedge Clk);
        drive(useB, 1'b1, wr, addr, wdata, be, 1'b1);
        #1;
        check({tag, ".reqReady"}, {31'h0, useB ? busB.ReqReady : busA.ReqReady}, 32'h1);
        @(posedge Clk);
        #1;
        drive(useB, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        lat = 1;
        while (!respValidOf(useB) && lat < 20) begin
            @(posedge Clk);
            #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(expLat));
        rdata = useB ? busB.RespRData : busA.RespRData;
        err   = useB ? busB.RespErr : busA.RespErr;
        @(posedge Clk);
        #1;
        check({tag, ".respDone"}, {31'h0, respValidOf(useB)}, 32'h0);
    endtask

    logic [31:0] rd;
    logic        er;
    logic [31:0] word10;
    logic [31:0] held;

    initial begin
        checks   = 0;
        failures = 0;
        rstA = 1'b0;
        rstB = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

        // Reset for three cycles
        repeat (3) @(posedge Clk);
        #1;
        check("rst.reqReady", {31'h0, busA.ReqReady}, 32'h1);
        check("rst.respValid", {31'h0, busA.RespValid}, 32'h0);
        check("rst.rdata", busA.RespRData, 32'h0);
        check("rst.err", {31'h0, busA.RespErr}, 32'h0);
        @(negedge Clk);
        rstA = 1'b1;
        rstB = 1'b1;
        @(posedge Clk);
        #1;
        check("rel.reqReady", {31'h0, busA.ReqReady}, 32'h1);
        check("rel.respValid", {31'h0, busA.RespValid}, 32'h0);
        check("rel.rdata", busA.RespRData, 32'h0);
        check("rel.err", {31'h0, busA.RespErr}, 32'h0);

        // Full-word store then load
        txn(1'b0, "st10", 1'b1, 32'h10, 32'h12345678, 4'b1111, 2, rd, er);
        check("st10.rdata", rd, 32'h0);
        check("st10.err", {31'h0, er}, 32'h0);
        txn(1'b0, "ld10", 1'b0, 32'h10, 32'h0, 4'b0000, 2, rd, er);
        check("ld10.rdata", rd, 32'h12345678);
        check("ld10.err", {31'h0, er}, 32'h0);

        // Partial store, lanes 0 and 2
        txn(1'b0, "stpart", 1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, 2, rd, er);
`ifdef DM_ALIGN_CHECK_EN
        check("stpart.err", {31'h0, er}, 32'h1);
        word10 = 32'h12345678;
`else
        check("stpart.err", {31'h0, er}, 32'h0);
        word10 = 32'h12BB56DD;
`endif
        txn(1'b0, "ldpart", 1'b0, 32'h10, 32'h0, 4'b1111, 2, rd, er);
        check("ldpart.rdata", rd, word10);

        // Response stall with RespReady low, then handshake overlapped with a new accept
        @(negedge Clk);
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        @(posedge Clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        check("stall.waitReqReady", {31'h0, busA.ReqReady}, 32'h0);
        @(posedge Clk);
        #1;
        check("stall.respValid", {31'h0, busA.RespValid}, 32'h1);
        held = busA.RespRData;
        check("stall.rdata", held, word10);
        repeat (5) begin
            @(posedge Clk);
            #1;
            check("stall.holdValid", {31'h0, busA.RespValid}, 32'h1);
            check("stall.holdData", busA.RespRData, word10);
            check("stall.reqReady", {31'h0, busA.ReqReady}, 32'h0);
        end
        @(negedge Clk);
        drive(1'b0, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 4'b1111, 1'b1);
        #1;
        check("b2b.reqReady", {31'h0, busA.ReqReady}, 32'h1);
        @(posedge Clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        check("b2b.waitValid", {31'h0, busA.RespValid}, 32'h0);
        @(posedge Clk);
        #1;
        check("b2b.respValid", {31'h0, busA.RespValid}, 32'h1);
        check("b2b.rdata", busA.RespRData, 32'h0);
        check("b2b.err", {31'h0, busA.RespErr}, 32'h0);
        @(posedge Clk);
        #1;
        txn(1'b0, "ld20", 1'b0, 32'h20, 32'h0, 4'h0, 2, rd, er);
        check("ld20.rdata", rd, 32'hCAFEF00D);

        // Out-of-range store must not alias onto word 0
        txn(1'b0, "st0", 1'b1, 32'h0, 32'h55AA0001, 4'b1111, 2, rd, er);
        txn(1'b0, "stoor", 1'b1, 32'h0000_4000, 32'hDEADBEEF, 4'b1111, 2, rd, er);
        check("stoor.err", {31'h0, er}, 32'h1);
        check("stoor.rdata", rd, 32'h0);
        txn(1'b0, "ld0", 1'b0, 32'h0, 32'h0, 4'h0, 2, rd, er);
        check("ld0.rdata", rd, 32'h55AA0001);
        check("ld0.err", {31'h0, er}, 32'h0);

        // Misaligned load
        txn(1'b0, "ld12", 1'b0, 32'h12, 32'h0, 4'h0, 2, rd, er);
`ifdef DM_ALIGN_CHECK_EN
        check("ld12.err", {31'h0, er}, 32'h1);
        check("ld12.rdata", rd, 32'h0);
`else
        check("ld12.err", {31'h0, er}, 32'h0);
        check("ld12.rdata", rd, word10);
`endif

        // LATENCY=4: reset mid-wait discards the captured store
        txn(1'b1, "bst", 1'b1, 32'h30, 32'h11111111, 4'b1111, 4, rd, er);
        check("bst.err", {31'h0, er}, 32'h0);
        @(negedge Clk);
        drive(1'b1, 1'b1, 1'b1, 32'h30, 32'h22222222, 4'b1111, 1'b1);
        @(posedge Clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        check("brst.waitReqReady", {31'h0, busB.ReqReady}, 32'h0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        rstB = 1'b0;
        #1;
        check("brst.inReset", {31'h0, busB.RespValid}, 32'h0);
        check("brst.reqReady", {31'h0, busB.ReqReady}, 32'h1);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        rstB = 1'b1;
        repeat (6) begin
            @(posedge Clk);
            #1;
            check("brst.noResp", {31'h0, busB.RespValid}, 32'h0);
        end
        txn(1'b1, "bld", 1'b0, 32'h30, 32'h0, 4'h0, 4, rd, er);
        check("bld.rdata", rd, 32'h11111111);
        check("bld.err", {31'h0, er}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
